// File: rtl/carry_sum_stage.sv
// Final stage of the parallel-prefix adder: resolves group carry-ins from the
// prefix tree output, ripples within each group and registers sum and flags.
module carry_sum_stage #(
    parameter int WIDTH  = 32,
    parameter int GROUP  = 4,
    parameter int NGROUP = WIDTH / GROUP
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      bit_p,
    input  logic [WIDTH-1:0]      bit_g,
    input  logic [2*NGROUP-1:0]   grp_gp,
    input  logic                  cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      sum,
    output logic                  cout,
    output logic                  ovf,
    output logic                  zero
);

    logic              s1_valid;
    logic [WIDTH-1:0]  s1_p;
    logic [WIDTH-1:0]  s1_g;
    logic [NGROUP-1:0] s1_cgrp;
    logic              s1_cfinal;
    logic              s2_valid;

    // Elastic handshake: a stage advances when it is empty or the stage after
    // it advances; a transfer happens on an edge where valid && ready, so
    // in_ready depends only on registered valids and out_ready.
    logic s1_advance;
    logic s2_advance;
    assign s2_advance = ~s2_valid | out_ready;
    assign s1_advance = ~s1_valid | s2_advance;
    assign in_ready   = s1_advance;
    assign out_valid  = s2_valid;

    // Group prefix pairs exclude cin, so fold it in here.
    logic [NGROUP-1:0] c_grp_n;
    logic              c_final_n;
    always_comb begin
        c_grp_n    = '0;
        c_grp_n[0] = cin;
        for (int i = 1; i < NGROUP; i++) begin
            c_grp_n[i] = grp_gp[2*i-1] | (grp_gp[2*i-2] & cin);
        end
        c_final_n = grp_gp[2*NGROUP-1] | (grp_gp[2*NGROUP-2] & cin);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_p      <= '0;
            s1_g      <= '0;
            s1_cgrp   <= '0;
            s1_cfinal <= 1'b0;
        end else if (s1_advance) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_p      <= bit_p;
                s1_g      <= bit_g;
                s1_cgrp   <= c_grp_n;
                s1_cfinal <= c_final_n;
            end
        end
    end

    // Intra-group ripple; msb_c is the carry into the sign bit for overflow.
    logic [WIDTH-1:0] sum_n;
    logic             msb_c;
    logic             ripple_c;
    always_comb begin
        sum_n    = '0;
        msb_c    = 1'b0;
        ripple_c = 1'b0;
        for (int i = 0; i < NGROUP; i++) begin
            ripple_c = s1_cgrp[i];
            for (int j = 0; j < GROUP; j++) begin
                sum_n[GROUP*i+j] = s1_p[GROUP*i+j] ^ ripple_c;
                if (GROUP*i+j == WIDTH-1) begin
                    msb_c = ripple_c;
                end
                ripple_c = s1_g[GROUP*i+j] | (s1_p[GROUP*i+j] & ripple_c);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            ovf      <= 1'b0;
            zero     <= 1'b0;
        end else if (s2_advance) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                sum  <= sum_n;
                cout <= s1_cfinal;
                ovf  <= msb_c ^ s1_cfinal;
                zero <= ~|sum_n;
            end
        end
    end

endmodule
